// File: rtl/jtframe_pocket_dwnld_pkg.sv
// Shared definitions for the Pocket download sequencer: FSM state encodings,
// the bridge command page and a big-endian byte selector.
package jtframe_pocket_dwnld_pkg;

    // Upper address byte of the bridge command space; such writes are not ROM data.
    localparam logic [7:0] BRIDGE_CMD_PAGE = 8'hF8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_POP  = 2'd1,
        ST_BYTE = 2'd2,
        ST_WAIT = 2'd3
    } dl_state_t;

    // Byte idx of a bridge word, byte 0 being the most significant one.
    function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = w[31:24];
            2'd1:    b = w[23:16];
            2'd2:    b = w[15:8];
            default: b = w[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/jtframe_pocket_wfifo.sv
// Synchronous word FIFO for the Pocket download path. First-word fall-through:
// rdata always shows the oldest entry. full/empty are registered flags.
module jtframe_pocket_wfifo #(
    parameter int AW = 3,
    parameter int DW = 55
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    localparam logic [AW:0] FULL_CNT = {1'b1, {AW{1'b0}}};

    logic [DW-1:0] mem [2**AW];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_pop;
    logic          do_push;
    logic [AW:0]   count_nxt;

    // A pop frees a slot before the push lands, so push+pop on a full FIFO is legal.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    // Next occupancy, used to register the status flags.
    always_comb begin
        count_nxt = count;
        if (do_push && !do_pop)
            count_nxt = count + 1'b1;
        else if (do_pop && !do_push)
            count_nxt = count - 1'b1;
    end

    // Storage write.
    // NOTE: the data array has no reset; only pointers and count define validity,
    // which keeps the array mappable to RAM and avoids a reset fan-out per bit.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= wdata;
    end

    // Pointers, occupancy and status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count_nxt;
            full  <= (count_nxt == FULL_CNT);
            empty <= (count_nxt == '0);
        end
    end

endmodule

// File: rtl/jtframe_pocket_dwnld.sv
// Pocket bridge to JTFRAME ioctl download sequencer.
// Buffers 32-bit bridge words in a small FIFO and replays them as big-endian
// ioctl byte writes, paced by MIN_GAP and the loader's prog_rdy.
// Optional feature: define JTFRAME_DWNLD_SUM_EN to build the dl_sum byte checksum;
// otherwise dl_sum is tied to zero.
module jtframe_pocket_dwnld #(
    parameter int FIFO_AW = 3,
    parameter int AW      = 25,
    parameter int MIN_GAP = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          word_wr,
    input  logic [31:0]   word_addr,
    input  logic [31:0]   word_data,
    input  logic [7:0]    slot_id,
    input  logic          slot_done,
    input  logic          prog_rdy,
    output logic          word_full,
    output logic          err_ovf,
    output logic [AW-1:0] ioctl_addr,
    output logic [7:0]    ioctl_dout,
    output logic          ioctl_wr,
    output logic [7:0]    ioctl_index,
    output logic          downloading,
    output logic [15:0]   dl_sum
);

    import jtframe_pocket_dwnld_pkg::*;

    localparam int FW = AW - 2 + 32;

    dl_state_t        state;
    logic [1:0]       byte_cnt;
    logic [3:0]       gap_cnt;
    logic [AW-3:0]    cur_addr;
    logic [31:0]      cur_data;
    logic             done_latch;

    logic             wr_valid;
    logic             accept;
    logic             drop;
    logic             dl_start;
    logic             gap_ok;
    logic             wait_leave;
    logic             fifo_pop;
    logic             fifo_empty;
    logic [FW-1:0]    fifo_rdata;
    logic [FIFO_AW:0] fifo_count;
    logic             unused_addr_bits;

    // Word-aligned addresses: the byte lane bits carry no information.
    assign unused_addr_bits = ^word_addr[1:0];

    // Command-space writes never reach the FIFO and never count as overflow.
    assign wr_valid = word_wr && (word_addr[31:24] != BRIDGE_CMD_PAGE);
    assign accept   = wr_valid && (!word_full || fifo_pop);
    assign drop     = wr_valid && word_full && !fifo_pop;
    assign dl_start = accept && !downloading;

    // WAIT may end once MIN_GAP cycles have been spent in it and the loader is ready.
    assign gap_ok     = ({1'b0, gap_cnt} + 5'd1) >= 5'(MIN_GAP);
    assign wait_leave = (state == ST_WAIT) && gap_ok && prog_rdy;
    assign fifo_pop   = !fifo_empty &&
                        ((state == ST_IDLE) || (wait_leave && byte_cnt == 2'd3));

    jtframe_pocket_wfifo #(
        .AW (FIFO_AW),
        .DW (FW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (accept),
        .pop   (fifo_pop),
        .wdata ({word_addr[AW-1:2], word_data}),
        .rdata (fifo_rdata),
        .full  (word_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Byte sequencer: pops a word, emits its four bytes MSB first with pacing.
    // NOTE: all state here is updated with non-blocking assignments so every
    // branch sees the pre-edge values of state, byte_cnt and the ioctl registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            byte_cnt   <= 2'd0;
            gap_cnt    <= 4'd0;
            cur_addr   <= '0;
            cur_data   <= '0;
            ioctl_wr   <= 1'b0;
            ioctl_addr <= '0;
            ioctl_dout <= 8'd0;
        end else begin
            ioctl_wr <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        {cur_addr, cur_data} <= fifo_rdata;
                        state                <= ST_POP;
                    end
                end
                ST_POP: begin
                    byte_cnt   <= 2'd0;
                    ioctl_wr   <= 1'b1;
                    ioctl_addr <= {cur_addr, 2'd0};
                    ioctl_dout <= word_byte(cur_data, 2'd0);
                    state      <= ST_BYTE;
                end
                ST_BYTE: begin
                    gap_cnt <= 4'd0;
                    state   <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (gap_cnt != 4'hF)
                        gap_cnt <= gap_cnt + 4'd1;
                    if (wait_leave) begin
                        if (byte_cnt != 2'd3) begin
                            byte_cnt   <= byte_cnt + 2'd1;
                            ioctl_wr   <= 1'b1;
                            ioctl_addr <= {cur_addr, byte_cnt + 2'd1};
                            ioctl_dout <= word_byte(cur_data, byte_cnt + 2'd1);
                            state      <= ST_BYTE;
                        end else if (!fifo_empty) begin
                            {cur_addr, cur_data} <= fifo_rdata;
                            state                <= ST_POP;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Download window, slot index, overflow flag and end-of-transfer latch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            downloading <= 1'b0;
            ioctl_index <= 8'd0;
            err_ovf     <= 1'b0;
            done_latch  <= 1'b0;
        end else begin
            if (dl_start) begin
                downloading <= 1'b1;
                ioctl_index <= slot_id;
                err_ovf     <= 1'b0;
            end else if (drop) begin
                err_ovf <= 1'b1;
            end
            if (slot_done && downloading)
                done_latch <= 1'b1;
            // A word arriving in the closing cycle keeps the window open.
            if (downloading && done_latch && state == ST_IDLE &&
                fifo_count == '0 && !accept) begin
                downloading <= 1'b0;
                done_latch  <= 1'b0;
            end
        end
    end

`ifdef JTFRAME_DWNLD_SUM_EN
    // Running 16-bit sum of every byte written during the current download.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            dl_sum <= 16'd0;
        else if (dl_start)
            dl_sum <= 16'd0;
        else if (ioctl_wr)
            dl_sum <= dl_sum + {8'd0, ioctl_dout};
    end
`else
    assign dl_sum = 16'd0;
`endif

endmodule

// File: tb/tb_jtframe_pocket_dwnld.sv
// Self-checking bench for jtframe_pocket_dwnld: a byte-stream model built from
// accepted words is compared against every ioctl_wr seen on the DUT.
module tb_jtframe_pocket_dwnld;

    localparam int AW      = 25;
    localparam int MIN_GAP = 1;
    localparam int DEPTH   = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          word_wr;
    logic [31:0]   word_addr;
    logic [31:0]   word_data;
    logic [7:0]    slot_id;
    logic          slot_done;
    logic          prog_rdy;
    logic          word_full;
    logic          err_ovf;
    logic [AW-1:0] ioctl_addr;
    logic [7:0]    ioctl_dout;
    logic          ioctl_wr;
    logic [7:0]    ioctl_index;
    logic          downloading;
    logic [15:0]   dl_sum;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [AW-1:0] exp_addr[$];
    logic [7:0]    exp_data[$];
    logic [AW-1:0] mon_addr[$];
    logic [7:0]    mon_data[$];
    int            mon_cyc[$];

    jtframe_pocket_dwnld #(
        .FIFO_AW (3),
        .AW      (AW),
        .MIN_GAP (MIN_GAP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .word_wr     (word_wr),
        .word_addr   (word_addr),
        .word_data   (word_data),
        .slot_id     (slot_id),
        .slot_done   (slot_done),
        .prog_rdy    (prog_rdy),
        .word_full   (word_full),
        .err_ovf     (err_ovf),
        .ioctl_addr  (ioctl_addr),
        .ioctl_dout  (ioctl_dout),
        .ioctl_wr    (ioctl_wr),
        .ioctl_index (ioctl_index),
        .downloading (downloading),
        .dl_sum      (dl_sum)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Byte monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (ioctl_wr) begin
            mon_addr.push_back(ioctl_addr);
            mon_data.push_back(ioctl_dout);
            mon_cyc.push_back(cyc);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_queues();
        exp_addr.delete();
        exp_data.delete();
        mon_addr.delete();
        mon_data.delete();
        mon_cyc.delete();
    endtask

    // Reference: a word at byte address a produces bytes a&~3 .. +3, MSB first.
    task automatic model_word(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] ba;
        logic [31:0] sh;
        for (int i = 0; i < 4; i++) begin
            ba = (a & 32'hFFFF_FFFC) + 32'(i);
            sh = d >> (8 * (3 - i));
            exp_addr.push_back(ba[AW-1:0]);
            exp_data.push_back(sh[7:0]);
        end
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = $urandom;
        while (a[31:24] == 8'hF8) a = $urandom;
        return a;
    endfunction

    // Drives a one-cycle word strobe; t returns the cycle that sampled it.
    task automatic send_word(input logic [31:0] a, input logic [31:0] d,
                             input logic [7:0] sid, output int t);
        word_wr   = 1'b1;
        word_addr = a;
        word_data = d;
        slot_id   = sid;
        step();
        t       = cyc;
        word_wr = 1'b0;
    endtask

    task automatic wait_bytes(input int n, input int budget, input string name);
        int k = 0;
        while (mon_addr.size() < n && k < budget) begin
            @(negedge clk);
            #1;
            k++;
        end
        checks++;
        if (mon_addr.size() < n) begin
            errors++;
            $display("FAIL %s timeout: got %0d bytes, required %0d", name, mon_addr.size(), n);
        end
    endtask

    task automatic compare_stream(input string name);
        int n;
        checks++;
        if (mon_addr.size() != exp_addr.size()) begin
            errors++;
            $display("FAIL %s byte count: got %0d, required %0d", name, mon_addr.size(), exp_addr.size());
        end
        n = (mon_addr.size() < exp_addr.size()) ? mon_addr.size() : exp_addr.size();
        for (int i = 0; i < n; i++) begin
            checks++;
            if (mon_addr[i] !== exp_addr[i] || mon_data[i] !== exp_data[i]) begin
                errors++;
                $display("FAIL %s byte %0d: got addr %h data %h, required addr %h data %h",
                         name, i, mon_addr[i], mon_data[i], exp_addr[i], exp_data[i]);
            end
        end
    endtask

    task automatic finish_dl(input string name);
        int k = 0;
        slot_done = 1'b1;
        step();
        slot_done = 1'b0;
        while (downloading && k < 500) begin
            step();
            k++;
        end
        checks++;
        if (downloading !== 1'b0) begin
            errors++;
            $display("FAIL %s end of download: downloading=%b, required 0", name, downloading);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; word_wr = 1'b0; word_addr = '0; word_data = '0;
        slot_id = '0; slot_done = 1'b0; prog_rdy = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({word_full, err_ovf, ioctl_addr, ioctl_dout, ioctl_wr, ioctl_index, downloading, dl_sum} !== '0) begin
            errors++;
            $display("FAIL reset outputs: full=%b ovf=%b addr=%h dout=%h wr=%b idx=%h dl=%b sum=%h, required all 0",
                     word_full, err_ovf, ioctl_addr, ioctl_dout, ioctl_wr, ioctl_index, downloading, dl_sum);
        end
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_filter();
        int t;
        clear_queues();
        prog_rdy = 1'b1;
        send_word(32'hF800_0000, $urandom, 8'h05, t);
        repeat (10) step();
        checks++;
        if (mon_addr.size() != 0 || downloading !== 1'b0 || err_ovf !== 1'b0 || word_full !== 1'b0) begin
            errors++;
            $display("FAIL filter: bytes=%0d dl=%b ovf=%b full=%b, required 0 0 0 0",
                     mon_addr.size(), downloading, err_ovf, word_full);
        end
    endtask

    task automatic test_single();
        int t;
        clear_queues();
        prog_rdy = 1'b1;
        send_word(32'h0000_0100, 32'hA1B2_C3D4, 8'h12, t);
        model_word(32'h0000_0100, 32'hA1B2_C3D4);
        wait_bytes(4, 40, "single");
        compare_stream("single");
        for (int i = 0; i < 4 && i < mon_cyc.size(); i++) begin
            checks++;
            if (mon_cyc[i] != t + 2 + 2 * i) begin
                errors++;
                $display("FAIL single timing byte %0d: got cycle %0d, required %0d", i, mon_cyc[i], t + 2 + 2 * i);
            end
        end
        repeat (4) step();
        checks++;
        if (downloading !== 1'b1 || ioctl_index !== 8'h12 || ioctl_wr !== 1'b0 ||
            ioctl_addr !== 25'h103 || ioctl_dout !== 8'hD4) begin
            errors++;
            $display("FAIL single hold: dl=%b idx=%h wr=%b addr=%h dout=%h, required 1 12 0 103 d4",
                     downloading, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout);
        end
    endtask

    task automatic test_done();
        int t, e, f;
        logic [31:0] a, d;
        bit early_drop = 0;
        clear_queues();
        prog_rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a = rand_addr();
            d = $urandom;
            model_word(a, d);
            if (i == 2) slot_done = 1'b1;
            send_word(a, d, 8'h77, t);
            slot_done = 1'b0;
        end
        e = -1;
        f = -1;
        for (int k = 0; k < 200 && f < 0; k++) begin
            @(negedge clk);
            #1;
            if (mon_addr.size() >= 12 && e < 0) e = mon_cyc[11];
            if (!downloading) begin
                if (e < 0) early_drop = 1;
                f = cyc;
            end
        end
        checks++;
        if (early_drop || e < 0 || f <= e || f > e + 3) begin
            errors++;
            $display("FAIL done: 12th byte cycle %0d, downloading fell at %0d, required within 1..3 cycles after",
                     e, f);
        end
        compare_stream("done");
        checks++;
        if (ioctl_index !== 8'h12) begin
            errors++;
            $display("FAIL done index: got %h, required 12", ioctl_index);
        end
    endtask

    task automatic test_overflow();
        int t;
        logic [31:0] a, d;
        clear_queues();
        prog_rdy = 1'b0;
        for (int i = 0; i < 10; i++) begin
            a = rand_addr();
            d = $urandom;
            // The first word leaves the FIFO at once, so DEPTH more fit behind it.
            if (i < DEPTH + 1) model_word(a, d);
            send_word(a, d, 8'h34, t);
        end
        @(negedge clk);
        checks++;
        if (word_full !== 1'b1 || err_ovf !== 1'b1 || downloading !== 1'b1 || ioctl_index !== 8'h34) begin
            errors++;
            $display("FAIL overflow flags: full=%b ovf=%b dl=%b idx=%h, required 1 1 1 34",
                     word_full, err_ovf, downloading, ioctl_index);
        end
        step();
        prog_rdy = 1'b1;
        wait_bytes(4 * (DEPTH + 1), 600, "overflow");
        repeat (10) step();
        compare_stream("overflow");
        checks++;
        if (word_full !== 1'b0) begin
            errors++;
            $display("FAIL overflow drain: word_full=%b, required 0", word_full);
        end
        finish_dl("overflow");
    endtask

    task automatic test_random();
        int t;
        int n_words = 24;
        bit rnd_stop = 0;
        bit gap_bad  = 0;
        logic [7:0] sid;
        clear_queues();
        sid = 8'($urandom);
        fork
            begin
                while (!rnd_stop) begin
                    prog_rdy = 1'($urandom_range(0, 1));
                    step();
                end
            end
            begin
                logic [31:0] a, d;
                int k;
                for (int i = 0; i < n_words; i++) begin
                    repeat ($urandom_range(0, 3)) step();
                    k = 0;
                    while (word_full && k < 200) begin
                        step();
                        k++;
                    end
                    a = rand_addr();
                    d = $urandom;
                    model_word(a, d);
                    send_word(a, d, sid, t);
                    if (i == 0) begin
                        @(negedge clk);
                        checks++;
                        if (err_ovf !== 1'b0 || ioctl_index !== sid) begin
                            errors++;
                            $display("FAIL random start: ovf=%b idx=%h, required 0 %h", err_ovf, ioctl_index, sid);
                        end
                        step();
                    end
                end
                rnd_stop = 1;
            end
        join
        prog_rdy = 1'b1;
        wait_bytes(4 * n_words, 2000, "random");
        repeat (5) step();
        compare_stream("random");
        for (int i = 1; i < mon_cyc.size(); i++)
            if (mon_cyc[i] - mon_cyc[i-1] < MIN_GAP + 1) gap_bad = 1;
        checks++;
        if (gap_bad || err_ovf !== 1'b0) begin
            errors++;
            $display("FAIL random pacing: gap violation=%0d ovf=%b, required 0 0", gap_bad, err_ovf);
        end
        finish_dl("random");
    endtask

    task automatic test_stall();
        int t, n;
        clear_queues();
        prog_rdy = 1'b1;
        send_word(32'h0000_4440, 32'h5566_7788, 8'h21, t);
        model_word(32'h0000_4440, 32'h5566_7788);
        wait_bytes(1, 20, "stall first");
        step();
        prog_rdy = 1'b0;
        n = mon_addr.size();
        repeat (50) step();
        checks++;
        if (mon_addr.size() != n || n != 1) begin
            errors++;
            $display("FAIL stall: bytes during stall %0d (before %0d), required none after 1", mon_addr.size(), n);
        end
        prog_rdy = 1'b1;
        wait_bytes(4, 40, "stall resume");
        compare_stream("stall");
        finish_dl("stall");
    endtask

    task automatic test_rst_mid();
        int t, n;
        int exp_sum;
        clear_queues();
        prog_rdy = 1'b1;
        send_word(32'h0000_0200, $urandom, 8'h40, t);
        send_word(32'h0000_0204, $urandom, 8'h40, t);
        wait_bytes(2, 20, "rst mid");
        step();
        rst = 1'b1;
        #2;
        n = mon_addr.size();
        @(negedge clk);
        checks++;
        if ({word_full, err_ovf, ioctl_addr, ioctl_dout, ioctl_wr, ioctl_index, downloading, dl_sum} !== '0) begin
            errors++;
            $display("FAIL rst mid outputs: addr=%h dout=%h wr=%b idx=%h dl=%b sum=%h, required all 0",
                     ioctl_addr, ioctl_dout, ioctl_wr, ioctl_index, downloading, dl_sum);
        end
        repeat (2) step();
        rst = 1'b0;
        repeat (30) step();
        checks++;
        if (mon_addr.size() != n || downloading !== 1'b0) begin
            errors++;
            $display("FAIL rst mid discard: bytes %0d dl=%b, required %0d 0", mon_addr.size(), downloading, n);
        end
        clear_queues();
        send_word(32'h0000_0300, 32'h0102_0304, 8'h41, t);
        model_word(32'h0000_0300, 32'h0102_0304);
        wait_bytes(4, 40, "sum");
        repeat (3) step();
        compare_stream("sum");
`ifdef JTFRAME_DWNLD_SUM_EN
        exp_sum = 0;
        foreach (exp_data[i]) exp_sum += int'(exp_data[i]);
        exp_sum = exp_sum % 65536;
`else
        exp_sum = 0;
`endif
        checks++;
        if (dl_sum !== 16'(exp_sum) || ioctl_index !== 8'h41) begin
            errors++;
            $display("FAIL sum: dl_sum=%h idx=%h, required %h 41", dl_sum, ioctl_index, 16'(exp_sum));
        end
        finish_dl("sum");
    endtask

    initial begin
        test_reset();
        test_filter();
        test_single();
        test_done();
        test_overflow();
        test_random();
        test_stall();
        test_rst_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
